// File: rtl/dmem_access_ctrl.sv
// Data-memory sequencer for the MEM stage: little-endian lane handling on loads,
// read-modify-write for sub-word stores, and pipeline/debug-unit port sharing.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m_mem_read,
  input  logic              i_m_mem_write,
  input  logic [2:0]        i_m_bhw_type,
  input  logic [31:0]       i_m_addr,
  input  logic [31:0]       i_m_wdata,
  input  logic              i_m_halt,
  output logic [31:0]       o_m_rdata,
  output logic              o_m_stall,
  output logic              o_m_misalign,
  input  logic              i_du_req,
  input  logic [ADDR_W-1:0] i_du_addr,
  output logic              o_du_ack,
  output logic [31:0]       o_du_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE, DU_WAIT} state_e;
  typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B} size_e;

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       du_rdata_q, du_rdata_d;

  size_e             req_size;
  logic              req_uns;
  logic              pipe_op;
  logic              misalign_c;
  logic              du_grant;
  logic [ADDR_W-1:0] req_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^i_m_addr[31:ADDR_W+2];

  function automatic size_e decode_size(input logic [2:0] t);
    size_e s;
    unique case (t)
      3'b100, 3'b110: s = SZ_B;
      3'b010, 3'b111: s = SZ_H;
      default:        s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rd, input size_e sz,
                                               input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (lane)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    unique case (sz)
      SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rmw_merge(input logic [31:0] rd, input logic [15:0] wd,
                                             input size_e sz, input logic [1:0] lane);
    logic [31:0] m;
    m = rd;
    if (sz == SZ_B) begin
      unique case (lane)
        2'd0: m[7:0]   = wd[7:0];
        2'd1: m[15:8]  = wd[7:0];
        2'd2: m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    return m;
  endfunction

  always_comb begin
    req_size   = decode_size(i_m_bhw_type);
    req_uns    = (i_m_bhw_type == 3'b101) || (i_m_bhw_type == 3'b111) ||
                 (i_m_bhw_type == 3'b110);
    req_word   = i_m_addr[ADDR_W+1:2];
    pipe_op    = i_m_mem_read || i_m_mem_write;
    misalign_c = ((req_size == SZ_H) && i_m_addr[0]) ||
                 ((req_size == SZ_W) && (i_m_addr[1:0] != 2'b00));
    du_grant   = i_du_req && (!pipe_op || i_m_halt);
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    du_rdata_d   = du_rdata_q;
    o_m_rdata    = '0;
    o_m_stall    = 1'b0;
    o_m_misalign = 1'b0;
    o_du_ack     = 1'b0;
    o_du_rdata   = du_rdata_q;
    o_mem_addr   = addr_q;
    o_mem_we     = 1'b0;
    o_mem_wdata  = i_m_wdata;

    unique case (state_q)
      IDLE: begin
        o_mem_addr = req_word;
        // A halted pipeline yields to the DU; its pending op is held by the stall.
        if (du_grant) begin
          o_mem_addr = i_du_addr;
          addr_d     = i_du_addr;
          o_m_stall  = pipe_op;
          state_d    = DU_WAIT;
        end else if (pipe_op && misalign_c) begin
          o_m_misalign = 1'b1;
        end else if (i_m_mem_read) begin
          size_d    = req_size;
          uns_d     = req_uns;
          lane_d    = i_m_addr[1:0];
          addr_d    = req_word;
          o_m_stall = 1'b1;
          state_d   = LOAD_WAIT;
        end else if (i_m_mem_write && (req_size == SZ_W)) begin
          o_mem_we    = 1'b1;
          o_mem_wdata = i_m_wdata;
        end else if (i_m_mem_write) begin
          size_d    = req_size;
          uns_d     = req_uns;
          lane_d    = i_m_addr[1:0];
          addr_d    = req_word;
          wdata_d   = i_m_wdata[15:0];
          o_m_stall = 1'b1;
          state_d   = RMW_WRITE;
        end
      end
      LOAD_WAIT: begin
        o_m_rdata = load_extend(i_mem_rdata, size_q, uns_q, lane_q);
        state_d   = IDLE;
      end
      RMW_WRITE: begin
        o_mem_we    = 1'b1;
        o_mem_wdata = rmw_merge(i_mem_rdata, wdata_q, size_q, lane_q);
        state_d     = IDLE;
      end
      DU_WAIT: begin
        du_rdata_d = i_mem_rdata;
        o_du_rdata = i_mem_rdata;
        o_du_ack   = 1'b1;
        o_m_stall  = pipe_op;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      size_q     <= SZ_W;
      uns_q      <= 1'b0;
      lane_q     <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      du_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      du_rdata_q <= du_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: stimulus pushes expected memory writes,
// load results and DU reads; a negedge monitor pops and compares them.
module tb_dmem_access_ctrl;

  localparam int unsigned ADDR_W = 8;

  logic              i_clk;
  logic              i_reset;
  logic              i_m_mem_read;
  logic              i_m_mem_write;
  logic [2:0]        i_m_bhw_type;
  logic [31:0]       i_m_addr;
  logic [31:0]       i_m_wdata;
  logic              i_m_halt;
  logic [31:0]       o_m_rdata;
  logic              o_m_stall;
  logic              o_m_misalign;
  logic              i_du_req;
  logic [ADDR_W-1:0] i_du_addr;
  logic              o_du_ack;
  logic [31:0]       o_du_rdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m_mem_read(i_m_mem_read), .i_m_mem_write(i_m_mem_write),
    .i_m_bhw_type(i_m_bhw_type), .i_m_addr(i_m_addr), .i_m_wdata(i_m_wdata),
    .i_m_halt(i_m_halt), .o_m_rdata(o_m_rdata), .o_m_stall(o_m_stall),
    .o_m_misalign(o_m_misalign), .i_du_req(i_du_req), .i_du_addr(i_du_addr),
    .o_du_ack(o_du_ack), .o_du_rdata(o_du_rdata), .o_mem_addr(o_mem_addr),
    .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous single-port memory with a preload port for the bench.
  logic [31:0] mem [0:255];
  logic        pk_en;
  logic [7:0]  pk_addr;
  logic [31:0] pk_data;

  always @(posedge i_clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr];
  end

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic mis; logic [31:0] data; } ld_t;

  wr_t         exp_wr[$];
  ld_t         exp_ld[$];
  logic [31:0] exp_du[$];
  wr_t         mon_w;
  ld_t         mon_l;
  logic [31:0] mon_d;

  always @(negedge i_clk) begin
    if (i_reset) begin
      if (o_mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h", o_mem_addr, o_mem_wdata);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wr_addr", {24'd0, o_mem_addr}, {24'd0, mon_w.addr});
          check("wr_data", o_mem_wdata, mon_w.data);
        end
      end
      if (i_m_mem_read && !o_m_stall) begin
        if (exp_ld.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: got 0x%08h", o_m_rdata);
        end else begin
          mon_l = exp_ld.pop_front();
          check("ld_data", o_m_rdata, mon_l.data);
          check("ld_misalign", {31'd0, o_m_misalign}, {31'd0, mon_l.mis});
        end
      end
      if (o_du_ack) begin
        if (exp_du.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_du_ack: got 0x%08h", o_du_rdata);
        end else begin
          mon_d = exp_du.pop_front();
          check("du_rdata", o_du_rdata, mon_d);
        end
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(posedge i_clk); #1;
    pk_en = 1'b0;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_ld(input logic mis, input logic [31:0] d);
    ld_t l;
    l.mis = mis; l.data = d;
    exp_ld.push_back(l);
  endtask

  // Holds a pipeline request until the stall drops, as the MEM latch would.
  task automatic pipe_op(input logic rd, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d,
                         input int exp_stalls, input logic exp_mis, input string name);
    int   stalls;
    logic mis;
    logic done;
    stalls = 0; mis = 1'b0; done = 1'b0;
    i_m_mem_read = rd; i_m_mem_write = wr; i_m_bhw_type = t;
    i_m_addr = a; i_m_wdata = d;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge i_clk);
      if (o_m_misalign) mis = 1'b1;
      if (o_m_stall) stalls++;
      else done = 1'b1;
      if (!done) begin @(posedge i_clk); #1; end
    end
    check({name, "_stalls"}, stalls, exp_stalls);
    check({name, "_misalign"}, {31'd0, mis}, {31'd0, exp_mis});
    @(posedge i_clk); #1;
    i_m_mem_read = 1'b0; i_m_mem_write = 1'b0;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_du_ack) begin cyc = c; break; end
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   ack_cyc;
    int   stalls;
    logic stall_prev;

    i_reset = 1'b0; i_m_mem_read = 1'b0; i_m_mem_write = 1'b0; i_m_bhw_type = 3'b001;
    i_m_addr = '0; i_m_wdata = '0; i_m_halt = 1'b0; i_du_req = 1'b0; i_du_addr = '0;
    pk_en = 1'b0; pk_addr = '0; pk_data = '0;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_ctrl", {28'd0, o_m_stall, o_mem_we, o_du_ack, o_m_misalign}, 32'd0);
    check("reset_rdata", o_m_rdata, 32'd0);
    check("reset_du_rdata", o_du_rdata, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;

    // Reset while the RMW write is pending must drop the write entirely.
    poke(8'd4, 32'h11223344);
    i_m_mem_write = 1'b1; i_m_bhw_type = 3'b100; i_m_addr = 32'h11; i_m_wdata = 32'hAA;
    @(negedge i_clk);
    check("rst_rmw_stall", {31'd0, o_m_stall}, 32'd1);
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_m_mem_write = 1'b0;
    @(negedge i_clk);
    check("rst_rmw_ctrl", {28'd0, o_m_stall, o_mem_we, o_du_ack, o_m_misalign}, 32'd0);
    check("rst_rmw_rdata", o_m_rdata, 32'd0);
    check("rst_rmw_du_rdata", o_du_rdata, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(negedge i_clk);
    check("rst_rmw_mem", mem[4], 32'h11223344);
    @(posedge i_clk); #1;

    push_wr(8'd4, 32'h1122AA44);
    pipe_op(1'b0, 1'b1, 3'b100, 32'h11, 32'h000000AA, 1, 1'b0, "sb");
    poke(8'd4, 32'h11223344);
    push_wr(8'd4, 32'h55663344);
    pipe_op(1'b0, 1'b1, 3'b010, 32'h12, 32'h00005566, 1, 1'b0, "sh");
    check("sh_mem", mem[4], 32'h55663344);

    push_wr(8'd4, 32'hDEADBEEF);
    pipe_op(1'b0, 1'b1, 3'b001, 32'h10, 32'hDEADBEEF, 0, 1'b0, "sw");
    push_ld(1'b0, 32'hDEADBEEF);
    pipe_op(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 1, 1'b0, "lw");
    push_ld(1'b0, 32'hFFFFFFBE);
    pipe_op(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 1, 1'b0, "lb11");
    push_ld(1'b0, 32'h000000BE);
    pipe_op(1'b1, 1'b0, 3'b110, 32'h11, 32'h0, 1, 1'b0, "lbu11");
    push_ld(1'b0, 32'hFFFFFFEF);
    pipe_op(1'b1, 1'b0, 3'b100, 32'h10, 32'h0, 1, 1'b0, "lb10");
    push_ld(1'b0, 32'hFFFFFFDE);
    pipe_op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1, 1'b0, "lb13");
    push_ld(1'b0, 32'hFFFFDEAD);
    pipe_op(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 1, 1'b0, "lh12");
    push_ld(1'b0, 32'h0000DEAD);
    pipe_op(1'b1, 1'b0, 3'b111, 32'h12, 32'h0, 1, 1'b0, "lhu12");
    push_ld(1'b0, 32'h0000BEEF);
    pipe_op(1'b1, 1'b0, 3'b111, 32'h10, 32'h0, 1, 1'b0, "lhu10");
    push_ld(1'b1, 32'h0);
    pipe_op(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, 0, 1'b1, "lh13_mis");
    push_ld(1'b1, 32'h0);
    pipe_op(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 0, 1'b1, "lw12_mis");
    pipe_op(1'b0, 1'b1, 3'b001, 32'h12, 32'h12345678, 0, 1'b1, "sw12_mis");
    pipe_op(1'b0, 1'b1, 3'b010, 32'h11, 32'h00001234, 0, 1'b1, "sh11_mis");
    check("mis_mem", mem[4], 32'hDEADBEEF);

    // Pipeline load beats a concurrent DU request when not halted.
    push_ld(1'b0, 32'hDEADBEEF);
    exp_du.push_back(32'hDEADBEEF);
    i_m_mem_read = 1'b1; i_m_bhw_type = 3'b001; i_m_addr = 32'h10;
    i_du_req = 1'b1; i_du_addr = 8'd4;
    ack_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (c == 0) check("arb_stall0", {31'd0, o_m_stall}, 32'd1);
      stall_prev = o_m_stall;
      if (o_du_ack) begin ack_cyc = c; break; end
      @(posedge i_clk); #1;
      if (!stall_prev) i_m_mem_read = 1'b0;
    end
    check("arb_ack_cycle", ack_cyc, 32'd3);
    @(posedge i_clk); #1;
    i_du_req = 1'b0;

    // Pipeline op arriving during DU_WAIT is stalled, then serviced.
    poke(8'd9, 32'hCAFEF00D);
    exp_du.push_back(32'hCAFEF00D);
    i_du_req = 1'b1; i_du_addr = 8'd9;
    @(negedge i_clk);
    check("du_grant_ctrl", {30'd0, o_du_ack, o_m_stall}, 32'd0);
    @(posedge i_clk); #1;
    push_ld(1'b0, 32'hDEADBEEF);
    i_m_mem_read = 1'b1; i_m_bhw_type = 3'b001; i_m_addr = 32'h10;
    @(negedge i_clk);
    check("du_wait_ctrl", {30'd0, o_du_ack, o_m_stall}, 32'd3);
    @(posedge i_clk); #1;
    i_du_req = 1'b0;
    pipe_op(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 1, 1'b0, "du_then_lw");
    check("du_rdata_hold", o_du_rdata, 32'hCAFEF00D);

    // Halted pipeline: DU wins even with a load pending.
    poke(8'd5, 32'h0BADF00D);
    exp_du.push_back(32'h0BADF00D);
    push_ld(1'b0, 32'hDEADBEEF);
    i_m_halt = 1'b1; i_du_req = 1'b1; i_du_addr = 8'd5;
    i_m_mem_read = 1'b1; i_m_bhw_type = 3'b001; i_m_addr = 32'h10;
    wait_ack(ack_cyc);
    check("halt_ack_cycle", ack_cyc, 32'd1);
    @(posedge i_clk); #1;
    i_m_halt = 1'b0; i_du_req = 1'b0;
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (!o_m_stall) break;
      stalls++;
      @(posedge i_clk); #1;
    end
    check("halt_lw_stalls", stalls, 32'd1);
    @(posedge i_clk); #1;
    i_m_mem_read = 1'b0;

    repeat (3) @(posedge i_clk);
    #1;
    check("wr_queue_empty", exp_wr.size(), 32'd0);
    check("ld_queue_empty", exp_ld.size(), 32'd0);
    check("du_queue_empty", exp_du.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
